des3_key_scheduler: RTL and testbench

DES3_KEY_SCHEDULER -- requirements
Module: des3_key_scheduler

---
 rtl/des3_key_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_des3_key_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des3_key_scheduler.sv
// DES / Triple-DES round-key generator: walks the C/D halves through the 16-round
// shift schedule per stage and streams PC2 round keys over a valid/ready handshake.
module des3_key_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_encrypt,
    input  logic        mode_3des,
    input  logic [0:55] key1,
    input  logic [0:55] key2,
    input  logic [0:55] key3,
    input  logic        round_ready,
    output logic [0:47] round_key,
    output logic        round_key_valid,
    output logic [3:0]  round_num,
    output logic [1:0]  stage,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Zero-based PC2 source indices into the 56-bit {C,D} vector.
    localparam logic [5:0] PC2_IDX [0:47] = '{
        6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,  6'd2,  6'd27,
        6'd14, 6'd5,  6'd20, 6'd9,  6'd22, 6'd18, 6'd11, 6'd3,
        6'd25, 6'd7,  6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
        6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54, 6'd29, 6'd39,
        6'd50, 6'd44, 6'd32, 6'd47, 6'd43, 6'd48, 6'd38, 6'd55,
        6'd33, 6'd52, 6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
    };

    state_t      state_r, state_n_s;
    logic [0:55] cd_r, cd_n_s;
    logic [3:0]  round_r, round_n_s;
    logic [1:0]  stage_r, stage_n_s;
    logic [0:55] k1_r, k2_r, k3_r;
    logic        enc_r, mode_r;
    logic        last_stage_s;

    function automatic logic [0:27] rotl28(input logic [0:27] x, input logic [1:0] n);
        logic [0:27] r;
        if (n == 2'd2) r = {x[2:27], x[0:1]};
        else           r = {x[1:27], x[0]};
        return r;
    endfunction

    function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] n);
        logic [0:27] r;
        if (n == 2'd2) r = {x[26:27], x[0:25]};
        else           r = {x[27], x[0:26]};
        return r;
    endfunction

    function automatic logic [1:0] shift_amt(input logic [3:0] rnd);
        logic [1:0] a;
        case (rnd)
            4'd0, 4'd1, 4'd8, 4'd15: a = 2'd1;
            default:                 a = 2'd2;
        endcase
        return a;
    endfunction

    // The middle stage of EDE runs in the opposite direction to the outer two.
    function automatic logic stage_dir(input logic [1:0] s, input logic enc, input logic m3);
        logic e;
        if (m3 && (s == 2'd1)) e = ~enc;
        else                   e = enc;
        return e;
    endfunction

    function automatic logic [0:55] stage_key(input logic [1:0] s, input logic enc, input logic m3,
                                              input logic [0:55] a, input logic [0:55] b,
                                              input logic [0:55] c);
        logic [0:55] k;
        if (!m3) begin
            k = a;
        end else begin
            case (s)
                2'd0:    k = enc ? a : c;
                2'd1:    k = b;
                default: k = enc ? c : a;
            endcase
        end
        return k;
    endfunction

    function automatic logic [0:55] load_cd(input logic [0:55] key, input logic dir_e);
        logic [0:55] r;
        if (dir_e) r = {rotl28(key[0:27], 2'd1), rotl28(key[28:55], 2'd1)};
        else       r = key;
        return r;
    endfunction

    function automatic logic [0:55] step_cd(input logic [0:55] cd, input logic dir_e,
                                            input logic [3:0] rnd);
        logic [0:55] r;
        logic [1:0]  amt;
        if (dir_e) begin
            amt = shift_amt(rnd + 4'd1);
            r   = {rotl28(cd[0:27], amt), rotl28(cd[28:55], amt)};
        end else begin
            amt = shift_amt(4'd15 - rnd);
            r   = {rotr28(cd[0:27], amt), rotr28(cd[28:55], amt)};
        end
        return r;
    endfunction

    function automatic logic [0:47] des_key_permutation2(input logic [0:55] cd);
        logic [0:47] k;
        for (int i = 0; i < 48; i++) k[i] = cd[PC2_IDX[i]];
        return k;
    endfunction

    assign last_stage_s = !mode_r || (stage_r == 2'd2);

    // Next-state and next C/D/round/stage logic.
    always_comb begin
        state_n_s = state_r;
        cd_n_s    = cd_r;
        round_n_s = round_r;
        stage_n_s = stage_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n_s = RUN;
                    round_n_s = 4'd0;
                    stage_n_s = 2'd0;
                    cd_n_s    = load_cd(stage_key(2'd0, is_encrypt, mode_3des, key1, key2, key3),
                                        stage_dir(2'd0, is_encrypt, mode_3des));
                end else begin
                    state_n_s = IDLE;
                end
            end
            RUN: begin
                if (round_ready) begin
                    if (round_r != 4'd15) begin
                        round_n_s = round_r + 4'd1;
                        cd_n_s    = step_cd(cd_r, stage_dir(stage_r, enc_r, mode_r), round_r);
                    end else if (last_stage_s) begin
                        state_n_s = DONE;
                    end else begin
                        // Reload straight into the next stage so no bubble appears.
                        stage_n_s = stage_r + 2'd1;
                        round_n_s = 4'd0;
                        cd_n_s    = load_cd(stage_key(stage_r + 2'd1, enc_r, mode_r, k1_r, k2_r, k3_r),
                                            stage_dir(stage_r + 2'd1, enc_r, mode_r));
                    end
                end else begin
                    state_n_s = RUN;
                end
            end
            DONE: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State, schedule registers and key/mode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cd_r    <= 56'd0;
            round_r <= 4'd0;
            stage_r <= 2'd0;
            k1_r    <= 56'd0;
            k2_r    <= 56'd0;
            k3_r    <= 56'd0;
            enc_r   <= 1'b0;
            mode_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            cd_r    <= cd_n_s;
            round_r <= round_n_s;
            stage_r <= stage_n_s;
            if ((state_r == IDLE) && start) begin
                k1_r   <= key1;
                k2_r   <= key2;
                k3_r   <= key3;
                enc_r  <= is_encrypt;
                mode_r <= mode_3des;
            end
        end
    end

    assign round_key       = des_key_permutation2(cd_r);
    assign round_key_valid = (state_r == RUN);
    assign round_num       = round_r;
    assign stage           = stage_r;
    assign busy            = (state_r != IDLE);
    assign done            = (state_r == DONE);

endmodule

// File: tb/tb_des3_key_scheduler.sv
// Scoreboard bench for des3_key_scheduler: a cumulative-shift DES key schedule model
// fills an expected queue per run; a negedge monitor compares every presented key.
module tb_des3_key_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, is_encrypt, mode_3des, round_ready;
    logic [55:0] key1, key2, key3;
    logic [47:0] round_key;
    logic        round_key_valid, busy, done;
    logic [3:0]  round_num;
    logic [1:0]  stage;

    always #5 clk = ~clk;

    des3_key_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .is_encrypt(is_encrypt), .mode_3des(mode_3des),
        .key1(key1), .key2(key2), .key3(key3), .round_ready(round_ready),
        .round_key(round_key), .round_key_valid(round_key_valid), .round_num(round_num),
        .stage(stage), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  rnd;
        logic [1:0]  stg;
    } exp_t;

    localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                                  26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                                  51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam logic [55:0] KEY_A = 56'hF0CCAAF556678F;
    localparam logic [47:0] K_FIRST = 48'h1B02EFFC7072;
    localparam logic [47:0] K_LAST  = 48'hCB3D8B0E17F5;

    exp_t        exp_q[$];
    logic [47:0] cap_q[$];
    logic [47:0] model_ks [16];
    exp_t        mon_e;
    int          checks = 0;
    int          passes = 0;
    int          done_cnt = 0;
    int          lat;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] expv);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        logic [27:0] r = x;
        for (int j = 0; j < n; j++) r = {r[26:0], r[27]};
        return r;
    endfunction

    // Bit n (1-based, DES numbering) of a 56-bit value is v[56-n].
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
        return k;
    endfunction

    task automatic des_sched(input logic [55:0] key);
        int cum = 0;
        for (int r = 0; r < 16; r++) begin
            cum += SHIFTS[r];
            model_ks[r] = pc2({rotl28(key[55:28], cum), rotl28(key[27:0], cum)});
        end
    endtask

    task automatic push_expected(input logic [55:0] a, input logic [55:0] b, input logic [55:0] c,
                                 input logic enc, input logic m3);
        logic [55:0] k;
        logic        e;
        int          nst = m3 ? 3 : 1;
        exp_t        x;
        for (int s = 0; s < nst; s++) begin
            if (!m3)       begin k = a; e = enc; end
            else if (enc)  begin k = (s == 0) ? a : (s == 1) ? b : c; e = (s != 1); end
            else           begin k = (s == 0) ? c : (s == 1) ? b : a; e = (s == 1); end
            des_sched(k);
            for (int r = 0; r < 16; r++) begin
                x.key = e ? model_ks[r] : model_ks[15-r];
                x.rnd = 4'(r);
                x.stg = 2'(s);
                exp_q.push_back(x);
            end
        end
    endtask

    function automatic logic [55:0] rand56();
        logic [63:0] t = {$urandom(), $urandom()};
        return t[55:0];
    endfunction

    // Monitor: compare whatever the DUT presents against the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (round_key_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_key", 64'(round_key), 64'd0);
                end else begin
                    mon_e = exp_q[0];
                    check(round_key == mon_e.key, "round_key", 64'(round_key), 64'(mon_e.key));
                    check(round_num == mon_e.rnd, "round_num", 64'(round_num), 64'(mon_e.rnd));
                    check(stage == mon_e.stg, "stage", 64'(stage), 64'(mon_e.stg));
                    if (round_ready) begin
                        exp_q.delete(0);
                        cap_q.push_back(round_key);
                    end
                end
            end
            if (done) begin
                check(exp_q.size() == 0, "done_with_keys_left", 64'(exp_q.size()), 64'd0);
                check(!round_key_valid, "valid_in_done", 64'(round_key_valid), 64'd0);
                done_cnt++;
            end
        end
    end

    task automatic run_sched(input logic [55:0] a, input logic [55:0] b, input logic [55:0] c,
                             input logic enc, input logic m3, input int ready_pct,
                             input bit disturb, output int latency);
        int cyc = 0;
        bit seen = 1'b0;
        int d0 = done_cnt;
        cap_q.delete();
        key1 = a; key2 = b; key3 = c; is_encrypt = enc; mode_3des = m3;
        push_expected(a, b, c, enc, m3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        latency = 0;
        while (!seen && cyc < 2000) begin
            round_ready = ($urandom_range(0, 99) < ready_pct);
            if (disturb) begin
                key1 = rand56(); key2 = rand56(); key3 = rand56();
                is_encrypt = 1'($urandom()); mode_3des = 1'($urandom());
                start = busy && !done && ($urandom_range(0, 3) == 0);
            end
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                seen = 1'b1;
                latency = cyc + 1;
            end
        end
        start = 1'b0;
        check(seen, "done_timeout", 64'(cyc), 64'd0);
        if (seen) begin
            @(posedge clk); #1;
            check(!done && !busy, "done_pulse_width", {62'd0, done, busy}, 64'd0);
            repeat (3) @(posedge clk);
            #1;
            check(done_cnt - d0 == 1, "done_count", 64'(done_cnt - d0), 64'd1);
        end else begin
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; is_encrypt = 1'b1; mode_3des = 1'b0; round_ready = 1'b0;
        key1 = KEY_A; key2 = 56'd0; key3 = 56'd0;
        repeat (2) @(posedge clk);
        #1;
        // start held high during reset must not launch a schedule
        check(!busy, "reset_busy", 64'(busy), 64'd0);
        check(!round_key_valid, "reset_valid", 64'(round_key_valid), 64'd0);
        check(!done, "reset_done", 64'(done), 64'd0);
        check(round_num == 4'd0, "reset_round", 64'(round_num), 64'd0);
        check(stage == 2'd0, "reset_stage", 64'(stage), 64'd0);
        check(round_key == 48'd0, "reset_key", 64'(round_key), 64'd0);
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        run_sched(KEY_A, 56'd0, 56'd0, 1'b1, 1'b0, 100, 1'b0, lat);
        check(lat == 17, "enc_done_latency", 64'(lat), 64'd17);
        check(cap_q.size() == 16, "enc_key_count", 64'(cap_q.size()), 64'd16);
        if (cap_q.size() == 16) begin
            check(cap_q[0] == K_FIRST, "enc_round0", 64'(cap_q[0]), 64'(K_FIRST));
            check(cap_q[15] == K_LAST, "enc_round15", 64'(cap_q[15]), 64'(K_LAST));
        end

        run_sched(KEY_A, 56'd0, 56'd0, 1'b0, 1'b0, 100, 1'b0, lat);
        check(cap_q.size() == 16, "dec_key_count", 64'(cap_q.size()), 64'd16);
        if (cap_q.size() == 16) begin
            check(cap_q[0] == K_LAST, "dec_round0", 64'(cap_q[0]), 64'(K_LAST));
            check(cap_q[15] == K_FIRST, "dec_round15", 64'(cap_q[15]), 64'(K_FIRST));
        end

        run_sched(KEY_A, rand56(), rand56(), 1'b1, 1'b1, 100, 1'b0, lat);
        check(lat == 49, "ede_done_latency", 64'(lat), 64'd49);
        check(cap_q.size() == 48, "ede_key_count", 64'(cap_q.size()), 64'd48);

        run_sched(KEY_A, 56'd0, 56'd0, 1'b1, 1'b0, 50, 1'b0, lat);
        check(cap_q.size() == 16, "stall_key_count", 64'(cap_q.size()), 64'd16);
        if (cap_q.size() == 16) begin
            check(cap_q[0] == K_FIRST, "stall_round0", 64'(cap_q[0]), 64'(K_FIRST));
            check(cap_q[15] == K_LAST, "stall_round15", 64'(cap_q[15]), 64'(K_LAST));
        end

        // Reset in the middle of stage 1
        begin
            bit hit = 1'b0;
            key1 = rand56(); key2 = rand56(); key3 = rand56();
            is_encrypt = 1'b1; mode_3des = 1'b1;
            push_expected(key1, key2, key3, 1'b1, 1'b1);
            start = 1'b1; round_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                if (stage == 2'd1 && round_num == 4'd7) hit = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check(hit, "reach_stage1_round7", 64'(hit), 64'd1);
            rst = 1'b1; round_ready = 1'b0;
            @(posedge clk); #1;
            check(!busy, "midrst_busy", 64'(busy), 64'd0);
            check(!round_key_valid, "midrst_valid", 64'(round_key_valid), 64'd0);
            check(round_num == 4'd0, "midrst_round", 64'(round_num), 64'd0);
            check(stage == 2'd0, "midrst_stage", 64'(stage), 64'd0);
            rst = 1'b0;
            exp_q.delete();
            @(posedge clk); #1;
        end
        run_sched(rand56(), rand56(), rand56(), 1'b1, 1'b1, 80, 1'b0, lat);

        run_sched(rand56(), rand56(), rand56(), 1'b0, 1'b1, 70, 1'b1, lat);
        check(cap_q.size() == 48, "disturb_key_count", 64'(cap_q.size()), 64'd48);

        for (int t = 0; t < 6; t++) begin
            run_sched(rand56(), rand56(), rand56(), 1'($urandom()), 1'($urandom()),
                      $urandom_range(30, 100), 1'($urandom()), lat);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
